// File: rtl/fc_argmax.sv
// fc_argmax: after the accelerator signals fc2_done, reads the FC2 class
// scores back from SRAM_f, finds the largest signed score (lowest index on a
// tie) and reports it with a single-cycle result_valid pulse.
//
// Read timing: the word address is presented while in RD, SRAM_f returns the
// word one cycle later, and that word is captured in r_rdata. It is compared
// one cycle after that. RD therefore runs one cycle past the last address, so
// the final word is still in flight. LAST compares that final word. The
// default 3-word scan takes 5 busy cycles, and FIN follows.
module fc_argmax #(
  parameter int NUM_CLASS      = 10,
  parameter int SCORE_WIDTH    = 8,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                                  clk,
  input  logic                                  srstn,
  input  logic                                  fc2_done,
  output logic [1:0]                            sram_raddr_f,
  input  logic [BYTES_PER_WORD*SCORE_WIDTH-1:0] sram_rdata_f,
  output logic                                  busy,
  output logic                                  result_valid,
  output logic [3:0]                            class_id,
  output logic [SCORE_WIDTH-1:0]                max_score
);

  localparam int NUM_WORDS = (NUM_CLASS + BYTES_PER_WORD - 1) / BYTES_PER_WORD;
  localparam logic [2:0] LP_WORDS = 3'(NUM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_LAST,
    S_FIN
  } state_t;

  state_t                                 r_state;
  state_t                                 w_next_state;
  logic [2:0]                             r_w;          // words issued so far
  logic                                   w_issue;
  logic                                   r_bus_vld;    // sram_rdata_f holds a requested word
  logic [1:0]                             r_bus_word;
  logic                                   r_data_vld;   // r_rdata holds a requested word
  logic [1:0]                             r_data_word;
  logic [BYTES_PER_WORD*SCORE_WIDTH-1:0]  r_rdata;
  logic                                   r_max_vld;    // running max is not "empty"
  logic signed [SCORE_WIDTH-1:0]          r_max;
  logic [3:0]                             r_idx;

  logic                                   w_word_vld;
  logic signed [SCORE_WIDTH-1:0]          w_word_max;
  logic [3:0]                             w_word_idx;
  logic signed [SCORE_WIDTH-1:0]          w_lane_score;
  logic [3:0]                             w_lane_idx;
  logic                                   w_take;
  logic signed [SCORE_WIDTH-1:0]          w_mrg_max;
  logic [3:0]                             w_mrg_idx;

  assign w_issue = (r_state == S_RD) && (r_w < LP_WORDS);

  // Next-state decode and the outputs derived from the state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
    w_next_state = r_state;
    busy         = 1'b0;
    result_valid = 1'b0;
    sram_raddr_f = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (fc2_done) w_next_state = S_RD;
      end
      S_RD: begin
        busy = 1'b1;
        if (w_issue) sram_raddr_f = r_w[1:0];
        if (r_w == LP_WORDS) w_next_state = S_LAST;
      end
      S_LAST: begin
        busy         = 1'b1;
        w_next_state = S_FIN;
      end
      S_FIN: begin
        result_valid = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Lane chain over the captured word (lane 0 first), then a strict-greater merge into the running max.
  always_comb begin
    w_word_vld   = 1'b0;
    w_word_max   = '0;
    w_word_idx   = '0;
    w_lane_score = '0;
    w_lane_idx   = '0;
    for (int j = 0; j < BYTES_PER_WORD; j++) begin
      w_lane_score = r_rdata[(BYTES_PER_WORD-j)*SCORE_WIDTH-1 -: SCORE_WIDTH];
      w_lane_idx   = {r_data_word, j[1:0]};
      if ((int'(w_lane_idx) < NUM_CLASS) && (!w_word_vld || (w_lane_score > w_word_max))) begin
        w_word_vld = 1'b1;
        w_word_max = w_lane_score;
        w_word_idx = w_lane_idx;
      end
    end
    w_take    = w_word_vld && (!r_max_vld || (w_word_max > r_max));
    w_mrg_max = w_take ? w_word_max : r_max;
    w_mrg_idx = w_take ? w_word_idx : r_idx;
  end

  // State, read pipeline, running max and result registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    if (srstn) begin
      r_state     <= S_IDLE;
      r_w         <= '0;
      r_bus_vld   <= 1'b0;
      r_bus_word  <= '0;
      r_data_vld  <= 1'b0;
      r_data_word <= '0;
      r_rdata     <= '0;
      r_max_vld   <= 1'b0;
      r_max       <= '0;
      r_idx       <= '0;
      class_id    <= '0;
      max_score   <= '0;
    end else begin
      r_state     <= w_next_state;
      r_bus_vld   <= w_issue;
      r_bus_word  <= r_w[1:0];
      r_data_vld  <= r_bus_vld;
      r_data_word <= r_bus_word;
      r_rdata     <= sram_rdata_f;

      if (r_state == S_IDLE) r_w <= '0;
      else if (w_issue)      r_w <= r_w + 3'd1;

      if ((r_state == S_IDLE) && fc2_done) begin
        r_max_vld <= 1'b0;
      end else if (r_data_vld) begin
        r_max_vld <= 1'b1;
        r_max     <= w_mrg_max;
        r_idx     <= w_mrg_idx;
      end

      // The final word merges in LAST, so the result becomes visible exactly in FIN.
      if (r_state == S_LAST) begin
        class_id  <= w_mrg_idx;
        max_score <= w_mrg_max;
      end
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Self-checking bench for fc_argmax: an SRAM_f read model, directed cases, and
// random score sets compared against a plain argmax reference.
module tb_fc_argmax;

  logic        clk = 1'b0;
  logic        srstn;
  logic        fc2_done;
  logic [1:0]  sram_raddr_f;
  logic [31:0] sram_rdata_f;
  logic        busy;
  logic        result_valid;
  logic [3:0]  class_id;
  logic [7:0]  max_score;

  logic [31:0]       mem [4];
  logic signed [7:0] scores [10];
  logic [7:0]        garbage;
  int                vals [10];
  int                n_checks = 0;
  int                n_errors = 0;

  always #5 clk = ~clk;

  fc_argmax dut (
    .clk          (clk),
    .srstn        (srstn),
    .fc2_done     (fc2_done),
    .sram_raddr_f (sram_raddr_f),
    .sram_rdata_f (sram_rdata_f),
    .busy         (busy),
    .result_valid (result_valid),
    .class_id     (class_id),
    .max_score    (max_score)
  );

  // SRAM_f read port: data appears one cycle after the address.
  always @(posedge clk) sram_rdata_f <= mem[sram_raddr_f];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_vals();
    for (int i = 0; i < 10; i++) scores[i] = 8'(vals[i]);
  endtask

  task automatic fill_mem();
    for (int w = 0; w < 4; w++) mem[w] = {4{garbage}};
    for (int i = 0; i < 10; i++) mem[i/4][31-8*(i%4) -: 8] = scores[i];
  endtask

  // Reference: first score seeds the max, later ones win only if strictly larger.
  task automatic ref_model(output int idx, output logic [7:0] mx);
    logic signed [7:0] best;
    best = scores[0];
    idx  = 0;
    for (int i = 1; i < 10; i++) begin
      if (scores[i] > best) begin
        best = scores[i];
        idx  = i;
      end
    end
    mx = best;
  endtask

  // Pulse fc2_done, watch 16 cycles, then check latency, busy length, addresses and result.
  // extra_k >= 0 re-pulses fc2_done so that it is sampled at edge T+extra_k+1.
  task automatic run_scan(input string tag, input int extra_k);
    int         lat, n_vld, n_busy, e_idx;
    logic [7:0] e_max, got_max;
    logic [3:0] got_id;
    logic [1:0] addr [3];
    fill_mem();
    ref_model(e_idx, e_max);
    lat = -1; n_vld = 0; n_busy = 0; got_id = '0; got_max = '0;
    fc2_done = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      if (busy) n_busy++;
      if (k < 3) addr[k] = sram_raddr_f;
      if (result_valid) begin
        n_vld++;
        if (lat < 0) begin
          lat     = k;
          got_id  = class_id;
          got_max = max_score;
        end
      end
      fc2_done = (k == extra_k);
      @(negedge clk);
    end
    fc2_done = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd5);
    check({tag, "_n_valid"}, 32'(n_vld), 32'd1);
    check({tag, "_busy_cycles"}, 32'(n_busy), 32'd5);
    for (int a = 0; a < 3; a++) check({tag, "_raddr"}, 32'(addr[a]), 32'(a));
    check({tag, "_class_id"}, 32'(got_id), 32'(e_idx));
    check({tag, "_max_score"}, 32'(got_max), 32'(e_max));
    check({tag, "_hold_id"}, 32'(class_id), 32'(e_idx));
  endtask

  initial begin
    int bad, n_vld;
    srstn    = 1'b1;
    fc2_done = 1'b0;
    garbage  = 8'h00;
    for (int w = 0; w < 4; w++) mem[w] = '0;
    repeat (3) @(negedge clk);
    srstn = 1'b0;

    // Reset state, then 20 idle cycles with nothing happening.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_class_id", 32'(class_id), 32'd0);
    check("rst_max_score", 32'(max_score), 32'd0);
    check("rst_raddr", 32'(sram_raddr_f), 32'd0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy || result_valid || (class_id != 0) || (max_score != 0) || (sram_raddr_f != 0)) bad++;
      @(negedge clk);
    end
    check("idle_quiet", 32'(bad), 32'd0);

    vals = '{3, -5, 7, 1, 0, 9, -128, 2, 8, 4};
    load_vals();
    run_scan("basic", -1);

    vals = '{10, 20, 0, 0, 20, 0, 0, 0, 0, 20};
    load_vals();
    run_scan("tie", -1);

    vals = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
    load_vals();
    run_scan("all_min", -1);
    check("all_min_raw", 32'(max_score), 32'h80);

    vals = '{1, -3, 5, 0, 2, 4, -7, 3, 5, 5};
    vals[2] = 4;
    load_vals();
    garbage = 8'h7F;
    run_scan("garbage", -1);
    check("garbage_id", 32'(class_id), 32'd8);
    garbage = 8'h00;

    vals = '{5, 6, 7, 8, 9, -1, -2, -3, -4, -5};
    load_vals();
    run_scan("dbl_pulse", 1);

    vals = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    load_vals();
    run_scan("last_class", -1);
    check("last_class_id", 32'(class_id), 32'd9);

    // Reset in the middle of RD abandons the scan.
    vals = '{50, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    load_vals();
    fill_mem();
    fc2_done = 1'b1;
    @(negedge clk);
    fc2_done = 1'b0;
    @(negedge clk);
    srstn = 1'b1;
    @(negedge clk);
    srstn = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(result_valid), 32'd0);
    check("midrst_class_id", 32'(class_id), 32'd0);
    check("midrst_max_score", 32'(max_score), 32'd0);
    check("midrst_raddr", 32'(sram_raddr_f), 32'd0);
    n_vld = 0;
    for (int c = 0; c < 10; c++) begin
      if (result_valid || busy) n_vld++;
      @(negedge clk);
    end
    check("midrst_no_result", 32'(n_vld), 32'd0);
    run_scan("after_rst", -1);

    // fc2_done together with reset: reset wins.
    srstn    = 1'b1;
    fc2_done = 1'b1;
    @(negedge clk);
    srstn    = 1'b0;
    fc2_done = 1'b0;
    @(negedge clk);
    check("rst_vs_done_busy", 32'(busy), 32'd0);
    @(negedge clk);

    // Random score sets; odd iterations use a narrow range to force ties.
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 10; i++) begin
        if (it % 2 == 1) vals[i] = int'($urandom_range(0, 3)) - 2;
        else             vals[i] = int'($urandom_range(0, 255)) - 128;
      end
      load_vals();
      garbage = 8'($urandom);
      run_scan("random", -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
